cache_line_ctrl: RTL and testbench
==================================

# cache_line_ctrl

Parametrised write-back, direct-mapped cache controller for the SoC data path. It sits between the processor memory port and the cache arrays. It sequences line fills and dirty-line write-backs through the LineFill (LB) and LineWrite (LW) AXI buffers, with critical-word-first restart and hit-under-fill on other lines. It also adds a full-cache flush walk that the single-configuration controller lacked.

## Interface
- WORDS_PER_LINE, 8: 32-bit words per line; power of two, 2..32; OFF_W = log2(WORDS_PER_LINE)
- LINES, 128: number of lines; power of two, 2..1024; IDX_W = log2(LINES)
- ADDR_W, 32: byte address width
- Clk  in  1  single clock; all state changes on rising edge
- Rst  in  1  synchronous, active-high reset
- En  in  1  processor access valid this cycle
- RW  in  1  1 = write, 0 = read
- WordAddress  in  ADDR_W  byte address; index = WordAddress[IDX_W+OFF_W+1 : OFF_W+2]
- Stall  out  1  combinational; processor holds En/RW/WordAddress while high
- C_Miss, C_Dirty  in  1 each  tag lookup for the presented index (for FlushIndex in flush states)
- R_Enable, W_Enable  out  1 each  combinational word read/write strobe to the arrays
- WriteType  out  1  1 = whole-line write from LB into the arrays
- Merge  out  1  merge the stalled store word into the LB line during the line write
- LB_Enable  out  1  start/hold the line fill; LB_FirstWord, LB_Completed  in  1 each
- LW_Enable  out  1  start/hold the victim write-back; LW_Completed  in  1
- CrtWord  out  1  forward the critical word from LB to the processor
- MissIndex  out  IDX_W  index of the outstanding miss
- FlushReq  in  1  one-cycle request to write back all dirty lines
- FlushIndex  out  IDX_W  line under flush scan
- CleanLine  out  1  one-cycle pulse: clear the dirty bit at FlushIndex
- FlushDone  out  1  one-cycle pulse when the flush completes

## Operation
- States: IDLE, MISS_DIRTY, MISS_CLEAN, WAIT_FILL, WRITE_LINE, FLUSH_SCAN, FLUSH_WB.
- IDLE, hit: R_Enable or W_Enable is asserted in the same cycle; Stall=0.
- IDLE, En & C_Miss:
  - Stall=1. Latch MissIndex, RW and a dirty flag.
  - Go to MISS_DIRTY (LB_Enable=1, LW_Enable=1) or MISS_CLEAN (LB_Enable=1 only).
- MISS_*:
  - Stall=1 until LB_FirstWord.
  - On the LB_FirstWord cycle, for a read: CrtWord=1, Stall=0, then go to WAIT_FILL.
  - For a write miss, stay stalled through WRITE_LINE.
- WAIT_FILL: sticky flags record LB_Completed and LW_Completed.
  - Hit to a different index proceeds with no stall.
  - Any access to MissIndex stalls, as does any new miss.
  - Go to WRITE_LINE when LB is done and, if the line was dirty, LW is done.
- LB_Enable and LW_Enable each drop on the cycle after their own Completed.
- WRITE_LINE, one cycle: WriteType=1; Merge=1 if the miss was a write. Stall=1 for accesses to MissIndex; then IDLE.
- Flush:
  - A FlushReq pulse is latched as pending. It is taken from IDLE only, with priority over a new access; that access stalls.
  - FLUSH_SCAN walks FlushIndex 0..LINES-1, one index per cycle, while C_Dirty=0.
  - If C_Dirty=1, go to FLUSH_WB: LW_Enable=1 until LW_Completed. On that cycle CleanLine=1; then resume the scan at the next index.
  - After index LINES-1 (wrap point), FlushDone=1 and return to IDLE.
  - Stall=1 for any En during flush.
- FlushReq during a miss is held pending and served on the next IDLE. A second FlushReq while one is pending or active is ignored.

## Timing
- Reset values:
  - State=IDLE; flush pending=0; sticky flags=0.
  - LB_Enable, LW_Enable, WriteType, Merge, CrtWord, CleanLine, FlushDone = 0; MissIndex=0; FlushIndex=0.
  - While Rst is high: R_Enable=W_Enable=0 and Stall=1.
- Rst mid-fill or mid-flush: the enables drop the next cycle, which aborts the buffers. No WriteType pulse is issued.
- Miss latency:
  - LB_Enable and LW_Enable rise one cycle after the miss is detected.
  - Read restarts on the LB_FirstWord cycle.
  - WRITE_LINE occurs one cycle after the last Completed; IDLE follows one cycle later.
- LB_Completed and LW_Completed arriving in the same cycle: both are recorded, and WRITE_LINE is next.
- LW_Completed before LB_FirstWord: recorded; it does not change the restart point.
- Flush of a clean cache takes LINES+1 cycles from acceptance to FlushDone.

## Test plan
- Read hit at 0x0000_0040 in IDLE -> R_Enable=1 and Stall=0 in the same cycle; no state change.
- Clean read miss at 0x100 (index 8), LB_FirstWord on cycle 4, LB_Completed on cycle 10 -> CrtWord=1 on cycle 4, WriteType=1 on cycle 11, IDLE on cycle 12.
- Dirty write miss; LB_Completed on cycle 6, LW_Completed on cycle 9 -> Stall held throughout; WRITE_LINE with Merge=1 on cycle 10; LB_Enable low from cycle 7.
- During WAIT_FILL for index 8: read hit at index 3 -> no stall; read at index 8 -> Stall until WRITE_LINE ends.
- LINES=4, lines 1 and 3 dirty, FlushReq -> LW_Enable and CleanLine for FlushIndex 1 and 3 only; then FlushDone=1.
- Rst asserted two cycles after a dirty miss starts -> LB_Enable=LW_Enable=0 the next cycle; IDLE; no WriteType.

Source files
------------

// File: rtl/cache_line_ctrl.sv
// Write-back, direct-mapped cache line controller: sequences line fills and victim
// write-backs through the LB/LW buffers, with critical-word restart, hit-under-fill and flush walk.
module cache_line_ctrl #(
    parameter int WORDS_PER_LINE = 8,
    parameter int LINES          = 128,
    parameter int ADDR_W         = 32,
    localparam int OFF_W         = $clog2(WORDS_PER_LINE),
    localparam int IDX_W         = $clog2(LINES)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              RW,
    input  logic [ADDR_W-1:0] WordAddress,
    output logic              Stall,
    input  logic              C_Miss,
    input  logic              C_Dirty,
    output logic              R_Enable,
    output logic              W_Enable,
    output logic              WriteType,
    output logic              Merge,
    output logic              LB_Enable,
    input  logic              LB_FirstWord,
    input  logic              LB_Completed,
    output logic              LW_Enable,
    input  logic              LW_Completed,
    output logic              CrtWord,
    output logic [IDX_W-1:0]  MissIndex,
    input  logic              FlushReq,
    output logic [IDX_W-1:0]  FlushIndex,
    output logic              CleanLine,
    output logic              FlushDone
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS_DIRTY,
        S_MISS_CLEAN,
        S_WAIT_FILL,
        S_WRITE_LINE,
        S_FLUSH_SCAN,
        S_FLUSH_WB
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  miss_idx_reg;
    logic              miss_rw_reg;
    logic              miss_dirty_reg;
    logic              lb_en_reg, lw_en_reg;
    logic              lb_done_reg, lw_done_reg;
    logic              flush_pend_reg;
    logic [IDX_W-1:0]  flush_idx_reg;
    logic              flush_done_reg;

    logic [IDX_W-1:0]  acc_idx;
    logic              lb_cmp, lw_cmp, fill_ok, flush_last, flush_active;
    logic              access_ok, miss_start, flush_start, flush_adv, flush_end, wb_start;
    logic              unused_addr_bits;

    assign acc_idx          = WordAddress[IDX_W+OFF_W+1 : OFF_W+2];
    assign unused_addr_bits = ^WordAddress;
    // Completions only count while the matching buffer is actually enabled.
    assign lb_cmp       = LB_Completed & lb_en_reg;
    assign lw_cmp       = LW_Completed & lw_en_reg;
    assign fill_ok      = (lb_done_reg | lb_cmp) & (~miss_dirty_reg | lw_done_reg | lw_cmp);
    assign flush_last   = (flush_idx_reg == IDX_W'(LINES - 1));
    assign flush_active = (state_reg == S_FLUSH_SCAN) || (state_reg == S_FLUSH_WB);

    always_comb begin
        state_next  = state_reg;
        Stall       = 1'b0;
        R_Enable    = 1'b0;
        W_Enable    = 1'b0;
        CrtWord     = 1'b0;
        WriteType   = 1'b0;
        Merge       = 1'b0;
        CleanLine   = 1'b0;
        access_ok   = 1'b0;
        miss_start  = 1'b0;
        flush_start = 1'b0;
        flush_adv   = 1'b0;
        flush_end   = 1'b0;
        wb_start    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (flush_pend_reg) begin
                    Stall       = En;
                    flush_start = 1'b1;
                    state_next  = S_FLUSH_SCAN;
                end else if (En) begin
                    if (C_Miss) begin
                        Stall      = 1'b1;
                        miss_start = 1'b1;
                        state_next = C_Dirty ? S_MISS_DIRTY : S_MISS_CLEAN;
                    end else begin
                        access_ok = 1'b1;
                    end
                end
            end
            S_MISS_DIRTY, S_MISS_CLEAN: begin
                Stall = 1'b1;
                if (LB_FirstWord) begin
                    state_next = S_WAIT_FILL;
                    if (!miss_rw_reg) begin
                        CrtWord = 1'b1;
                        Stall   = 1'b0;
                    end
                end
            end
            S_WAIT_FILL, S_WRITE_LINE: begin
                if (state_reg == S_WRITE_LINE) begin
                    WriteType  = 1'b1;
                    Merge      = miss_rw_reg;
                    state_next = S_IDLE;
                end else if (fill_ok) begin
                    state_next = S_WRITE_LINE;
                end
                // A pending store miss keeps the processor parked until the line is written.
                if (En) begin
                    if (miss_rw_reg || (acc_idx == miss_idx_reg) || C_Miss)
                        Stall = 1'b1;
                    else
                        access_ok = 1'b1;
                end
            end
            S_FLUSH_SCAN: begin
                Stall = En;
                if (C_Dirty) begin
                    wb_start   = 1'b1;
                    state_next = S_FLUSH_WB;
                end else begin
                    flush_adv = 1'b1;
                    if (flush_last) begin
                        flush_end  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_FLUSH_WB: begin
                Stall = En;
                if (lw_cmp) begin
                    CleanLine  = 1'b1;
                    flush_adv  = 1'b1;
                    flush_end  = flush_last;
                    state_next = flush_last ? S_IDLE : S_FLUSH_SCAN;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (access_ok) begin
            R_Enable = ~RW;
            W_Enable = RW;
        end
        if (Rst) begin
            Stall     = 1'b1;
            R_Enable  = 1'b0;
            W_Enable  = 1'b0;
            CrtWord   = 1'b0;
            WriteType = 1'b0;
            Merge     = 1'b0;
            CleanLine = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg      <= S_IDLE;
            miss_idx_reg   <= '0;
            miss_rw_reg    <= 1'b0;
            miss_dirty_reg <= 1'b0;
            lb_en_reg      <= 1'b0;
            lw_en_reg      <= 1'b0;
            lb_done_reg    <= 1'b0;
            lw_done_reg    <= 1'b0;
            flush_pend_reg <= 1'b0;
            flush_idx_reg  <= '0;
            flush_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            flush_done_reg <= flush_end;
            if (miss_start) begin
                miss_idx_reg   <= acc_idx;
                miss_rw_reg    <= RW;
                miss_dirty_reg <= C_Dirty;
                lb_en_reg      <= 1'b1;
                lw_en_reg      <= C_Dirty;
                lb_done_reg    <= 1'b0;
                lw_done_reg    <= 1'b0;
            end else begin
                if (lb_cmp) begin
                    lb_en_reg   <= 1'b0;
                    lb_done_reg <= 1'b1;
                end
                if (lw_cmp) begin
                    lw_en_reg   <= 1'b0;
                    lw_done_reg <= 1'b1;
                end
                if (wb_start)
                    lw_en_reg <= 1'b1;
            end
            if (flush_start)
                flush_pend_reg <= 1'b0;
            else if (FlushReq && !flush_active)
                flush_pend_reg <= 1'b1;
            if (flush_start)
                flush_idx_reg <= '0;
            else if (flush_adv)
                flush_idx_reg <= flush_idx_reg + 1'b1;
        end
    end

    assign LB_Enable  = lb_en_reg;
    assign LW_Enable  = lw_en_reg;
    assign MissIndex  = miss_idx_reg;
    assign FlushIndex = flush_idx_reg;
    assign FlushDone  = flush_done_reg;

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Scoreboard bench for cache_line_ctrl: per-cycle expectations are queued while stimulus
// is driven and compared on the falling edge.
module tb_cache_line_ctrl;
    localparam int LINES = 16;
    localparam int WPL   = 8;
    localparam int AW    = 32;
    localparam int IW    = 4;

    localparam int S_STALL = 0, S_REN = 1, S_WEN = 2, S_WT = 3, S_MERGE = 4, S_LBEN = 5;
    localparam int S_LWEN = 6, S_CRT = 7, S_MIDX = 8, S_FIDX = 9, S_CLEAN = 10, S_DONE = 11;

    logic          Clk = 1'b0;
    logic          Rst, En, RW, C_Miss, C_Dirty, C_Dirty_drv;
    logic [AW-1:0] WordAddress;
    logic          Stall, R_Enable, W_Enable, WriteType, Merge;
    logic          LB_Enable, LB_FirstWord, LB_Completed, LW_Enable, LW_Completed, CrtWord;
    logic [IW-1:0] MissIndex, FlushIndex;
    logic          FlushReq, CleanLine, FlushDone;
    logic          flush_mode;
    logic [LINES-1:0] dirty_map;

    // Tag array model during a flush: dirty bit of the line being scanned.
    assign C_Dirty = flush_mode ? dirty_map[FlushIndex] : C_Dirty_drv;

    always #5 Clk = ~Clk;

    cache_line_ctrl #(.WORDS_PER_LINE(WPL), .LINES(LINES), .ADDR_W(AW)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .RW(RW), .WordAddress(WordAddress), .Stall(Stall),
        .C_Miss(C_Miss), .C_Dirty(C_Dirty), .R_Enable(R_Enable), .W_Enable(W_Enable),
        .WriteType(WriteType), .Merge(Merge), .LB_Enable(LB_Enable),
        .LB_FirstWord(LB_FirstWord), .LB_Completed(LB_Completed), .LW_Enable(LW_Enable),
        .LW_Completed(LW_Completed), .CrtWord(CrtWord), .MissIndex(MissIndex),
        .FlushReq(FlushReq), .FlushIndex(FlushIndex), .CleanLine(CleanLine),
        .FlushDone(FlushDone)
    );

    typedef struct {
        string tag;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_val(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs == expv)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    function automatic int get_sig(input int sig);
        case (sig)
            S_STALL: return int'(Stall);
            S_REN:   return int'(R_Enable);
            S_WEN:   return int'(W_Enable);
            S_WT:    return int'(WriteType);
            S_MERGE: return int'(Merge);
            S_LBEN:  return int'(LB_Enable);
            S_LWEN:  return int'(LW_Enable);
            S_CRT:   return int'(CrtWord);
            S_MIDX:  return int'(MissIndex);
            S_FIDX:  return int'(FlushIndex);
            S_CLEAN: return int'(CleanLine);
            S_DONE:  return int'(FlushDone);
            default: return -1;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sig, input int val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, get_sig(e.sig), e.val);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        En = 1'b0; RW = 1'b0; WordAddress = '0; C_Miss = 1'b0; C_Dirty_drv = 1'b0;
        LB_FirstWord = 1'b0; LB_Completed = 1'b0; LW_Completed = 1'b0; FlushReq = 1'b0;
    endtask

    // One miss to 0x100 (index 8); cycle 0 is the detecting cycle.
    task automatic miss_txn(input string nm, input bit wr, input bit dirty,
                            input int fw, input int lbc, input int lwc);
        int last, wl;
        last = (dirty && lwc > lbc) ? lwc : lbc;
        wl   = last + 1;
        for (int c = 0; c <= wl + 1; c++) begin
            tick();
            idle_inputs();
            En           = wr ? 1'b1 : (c <= fw || c == wl + 1);
            RW           = wr;
            WordAddress  = 32'h0000_0100;
            C_Miss       = (c <= wl);
            C_Dirty_drv  = dirty;
            LB_FirstWord = (c == fw);
            LB_Completed = (c == lbc);
            LW_Completed = dirty && (c == lwc);
            if (c <= fw)
                expect_out($sformatf("%s_c%0d_stall", nm, c), S_STALL, (c == fw) ? int'(wr) : 1);
            else if (wr && c <= wl)
                expect_out($sformatf("%s_c%0d_stall", nm, c), S_STALL, 1);
            if (c >= 1 && c <= fw)
                expect_out($sformatf("%s_c%0d_crt", nm, c), S_CRT, int'(c == fw && !wr));
            if (c >= 1 && c <= wl) begin
                expect_out($sformatf("%s_c%0d_lben", nm, c), S_LBEN, int'(c <= lbc));
                expect_out($sformatf("%s_c%0d_lwen", nm, c), S_LWEN, int'(dirty && c <= lwc));
                expect_out($sformatf("%s_c%0d_midx", nm, c), S_MIDX, 8);
            end
            if (c >= 1) begin
                expect_out($sformatf("%s_c%0d_wt", nm, c), S_WT, int'(c == wl));
                expect_out($sformatf("%s_c%0d_merge", nm, c), S_MERGE, int'(c == wl && wr));
            end
            if (c == wl + 1) begin
                expect_out($sformatf("%s_idle_stall", nm), S_STALL, 0);
                expect_out($sformatf("%s_idle_ren", nm), S_REN, int'(!wr));
                expect_out($sformatf("%s_idle_wen", nm), S_WEN, int'(wr));
            end
        end
        tick();
        idle_inputs();
    endtask

    // Flush walk; cycle 0 carries FlushReq, cycle 1 is the accepting IDLE cycle.
    task automatic flush_txn(input string nm, input logic [LINES-1:0] dmap, input int wb_lat);
        int e_fidx[100];
        int e_clean[100];
        int e_lwen[100];
        int lwc_at[100];
        int t, done;
        for (int i = 0; i < 100; i++) begin
            e_fidx[i] = 0; e_clean[i] = 0; e_lwen[i] = 0; lwc_at[i] = 0;
        end
        t = 2;
        for (int idx = 0; idx < LINES; idx++) begin
            e_fidx[t] = idx;
            if (dmap[idx]) begin
                for (int k = 1; k <= wb_lat; k++) begin
                    e_fidx[t+k] = idx;
                    e_lwen[t+k] = 1;
                end
                e_clean[t+wb_lat] = 1;
                lwc_at[t+wb_lat]  = 1;
                t = t + wb_lat + 1;
            end else begin
                t = t + 1;
            end
        end
        done = t;
        dirty_map  = dmap;
        flush_mode = 1'b1;
        for (int c = 0; c <= done + 1; c++) begin
            tick();
            idle_inputs();
            FlushReq     = (c == 0 || c == 5);
            En           = (c == 1 || c == 6 || c == done + 1);
            WordAddress  = 32'h0000_0040;
            LW_Completed = (lwc_at[c] != 0);
            if (c == 1) begin
                expect_out($sformatf("%s_accept_stall", nm), S_STALL, 1);
                expect_out($sformatf("%s_accept_ren", nm), S_REN, 0);
            end
            if (c == 6)
                expect_out($sformatf("%s_busy_stall", nm), S_STALL, 1);
            if (c >= 2 && c < done) begin
                expect_out($sformatf("%s_c%0d_fidx", nm, c), S_FIDX, e_fidx[c]);
                expect_out($sformatf("%s_c%0d_clean", nm, c), S_CLEAN, e_clean[c]);
                expect_out($sformatf("%s_c%0d_lwen", nm, c), S_LWEN, e_lwen[c]);
                expect_out($sformatf("%s_c%0d_done", nm, c), S_DONE, 0);
            end
            if (c == done)
                expect_out($sformatf("%s_done", nm), S_DONE, 1);
            if (c == done + 1) begin
                expect_out($sformatf("%s_after_done", nm), S_DONE, 0);
                expect_out($sformatf("%s_after_stall", nm), S_STALL, 0);
                expect_out($sformatf("%s_after_ren", nm), S_REN, 1);
            end
        end
        tick();
        idle_inputs();
        flush_mode = 1'b0;
    endtask

    initial begin
        idle_inputs();
        flush_mode = 1'b0;
        dirty_map  = '0;
        Rst        = 1'b1;

        // Reset: hit presented while Rst is high must be stalled and not served.
        tick();
        En = 1'b1; WordAddress = 32'h0000_0040;
        expect_out("rst_stall", S_STALL, 1);
        expect_out("rst_ren", S_REN, 0);
        tick();
        expect_out("rst_lben", S_LBEN, 0);
        expect_out("rst_lwen", S_LWEN, 0);
        expect_out("rst_midx", S_MIDX, 0);
        expect_out("rst_fidx", S_FIDX, 0);
        expect_out("rst_done", S_DONE, 0);
        expect_out("rst_wt", S_WT, 0);
        tick();
        Rst = 1'b0;
        idle_inputs();

        // Read and write hits in IDLE.
        tick();
        En = 1'b1; RW = 1'b0; WordAddress = 32'h0000_0040;
        expect_out("hit_rd_ren", S_REN, 1);
        expect_out("hit_rd_stall", S_STALL, 0);
        expect_out("hit_rd_wen", S_WEN, 0);
        tick();
        RW = 1'b1;
        expect_out("hit_wr_wen", S_WEN, 1);
        expect_out("hit_wr_stall", S_STALL, 0);
        tick();
        idle_inputs();

        miss_txn("rd_clean", 1'b0, 1'b0, 4, 10, 0);
        miss_txn("wr_dirty", 1'b1, 1'b1, 3, 6, 9);
        miss_txn("rd_lw_early", 1'b0, 1'b1, 3, 5, 2);
        miss_txn("rd_same_cmp", 1'b0, 1'b1, 2, 4, 4);

        // Hit-under-fill: other index proceeds, miss index stalls until WRITE_LINE ends.
        for (int c = 0; c <= 8; c++) begin
            tick();
            idle_inputs();
            En           = 1'b1;
            WordAddress  = (c == 3) ? 32'h0000_0060 : 32'h0000_0100;
            C_Miss       = (c != 3) && (c <= 7);
            LB_FirstWord = (c == 2);
            LB_Completed = (c == 6);
            if (c == 2) expect_out("huf_crt", S_CRT, 1);
            if (c == 3) begin
                expect_out("huf_other_stall", S_STALL, 0);
                expect_out("huf_other_ren", S_REN, 1);
            end
            if (c >= 4 && c <= 7) begin
                expect_out($sformatf("huf_c%0d_stall", c), S_STALL, 1);
                expect_out($sformatf("huf_c%0d_ren", c), S_REN, 0);
            end
            if (c == 7) expect_out("huf_wt", S_WT, 1);
            if (c == 8) begin
                expect_out("huf_after_stall", S_STALL, 0);
                expect_out("huf_after_ren", S_REN, 1);
            end
        end
        tick();
        idle_inputs();

        // Reset two cycles into a dirty store miss aborts the buffers.
        for (int c = 0; c <= 7; c++) begin
            tick();
            idle_inputs();
            Rst          = (c == 2);
            En           = (c <= 2) || (c == 7);
            RW           = (c <= 2);
            WordAddress  = (c <= 2) ? 32'h0000_0100 : 32'h0000_0040;
            C_Miss       = (c <= 2);
            C_Dirty_drv  = (c <= 2);
            LB_Completed = (c == 4);
            LW_Completed = (c == 5);
            if (c == 1) begin
                expect_out("rstm_lben_on", S_LBEN, 1);
                expect_out("rstm_lwen_on", S_LWEN, 1);
            end
            if (c == 2) begin
                expect_out("rstm_stall", S_STALL, 1);
                expect_out("rstm_wen", S_WEN, 0);
            end
            if (c == 3) begin
                expect_out("rstm_lben_off", S_LBEN, 0);
                expect_out("rstm_lwen_off", S_LWEN, 0);
                expect_out("rstm_midx", S_MIDX, 0);
            end
            if (c >= 3 && c <= 6)
                expect_out($sformatf("rstm_c%0d_wt", c), S_WT, 0);
            if (c == 7) begin
                expect_out("rstm_idle_ren", S_REN, 1);
                expect_out("rstm_idle_stall", S_STALL, 0);
            end
        end
        tick();
        idle_inputs();

        flush_txn("flush_clean", 16'h0000, 3);
        flush_txn("flush_dirty", 16'h800A, 3);

        @(negedge Clk);
        #1;
        check_val("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
